// File: rtl/ex_trap_pkg.sv
// Shared definitions for the external-interrupt arbiter: register offsets,
// FSM state encoding and ID width.
package ex_trap_pkg;

    localparam int EXT_ID_W = 5;

    localparam logic [1:0] EXT_ENABLE  = 2'd0;
    localparam logic [1:0] EXT_PENDING = 2'd1;
    localparam logic [1:0] EXT_STATUS  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one interrupt line followed by a rising-edge
// detector producing a single-cycle rise pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic prev;

    // Reset to 1 so a line already high when reset releases is not taken as
    // an edge; only a fresh low->high after reset sets pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_1 <= irq;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign rise = sync_2 & ~prev;

endmodule

// File: rtl/ex_trap_arb.sv
// External-interrupt arbiter: edge-latched pending bits, lowest-ID-first
// offer to the core with valid/ready, in-service hold until completion.
//
// state   | meaning
// IDLE    | no request outstanding; waits for an enabled pending source
// REQ     | offering id to the core; held stable until trap_ready_i
// SVC     | id in service; waits for trap_cplet_i with matching id
module ex_trap_arb
    import ex_trap_pkg::*;
#(
    parameter int NSRC = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         irq_i,
    output logic                trap_valid_o,
    output logic [EXT_ID_W-1:0] trap_id_o,
    input  logic                trap_ready_i,
    input  logic                trap_cplet_i,
    input  logic [EXT_ID_W-1:0] trap_cplet_id_i,
    input  logic                icb_cmd_valid,
    output logic                icb_cmd_ready,
    input  logic [31:0]         icb_cmd_addr,
    input  logic                icb_cmd_read,
    input  logic [31:0]         icb_cmd_wdata,
    input  logic [3:0]          icb_cmd_wmask,
    output logic                icb_rsp_valid,
    input  logic                icb_rsp_ready,
    output logic                icb_rsp_err,
    output logic [31:0]         icb_rsp_rdata
);

    function automatic logic [31:0] impl_mask(input int nsrc);
        impl_mask = '0;
        for (int i = 1; i < 32; i++) begin
            if (i <= nsrc) impl_mask[i] = 1'b1;
        end
    endfunction

    function automatic logic [EXT_ID_W-1:0] prio_enc(input logic [31:0] v);
        prio_enc = '0;
        for (int i = 31; i >= 1; i--) begin
            if (v[i]) prio_enc = i[EXT_ID_W-1:0];
        end
    endfunction

    localparam logic [31:0] IMPL = impl_mask(NSRC);

    logic [31:0]         rise;
    logic [31:0]         pend;
    logic [31:0]         pend_nxt;
    logic [31:0]         en;
    logic [1:0]          state;
    logic [EXT_ID_W-1:0] id;

    assign rise[0] = 1'b0;
    for (genvar n = 1; n < 32; n++) begin : g_src
        if (n <= NSRC) begin : g_impl
            irq_sync_edge u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .irq   (irq_i[n]),
                .rise  (rise[n])
            );
        end else begin : g_unimpl
            assign rise[n] = 1'b0;
        end
    end

    logic        cmd_acc;
    logic [1:0]  sel;
    logic [31:0] bmask;
    logic        wr_en;
    logic        wr_pend;
    logic        claim;
    logic [31:0] status;
    logic [31:0] rd_val;

    assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
    assign cmd_acc = icb_cmd_valid & icb_cmd_ready;
    assign sel     = icb_cmd_addr[3:2];
    assign bmask   = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}},
                      {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
    assign wr_en   = cmd_acc & ~icb_cmd_read & (sel == EXT_ENABLE);
    assign wr_pend = cmd_acc & ~icb_cmd_read & (sel == EXT_PENDING);
    assign claim   = (state == ST_REQ) & trap_ready_i;
    assign status  = {(state != ST_IDLE), 26'd0, id};

    // Clears first, new edges last: a coincident edge beats W1C and claim.
    always_comb begin
        pend_nxt = pend;
        if (wr_pend) pend_nxt = pend_nxt & ~(icb_cmd_wdata & bmask);
        if (claim) pend_nxt[id] = 1'b0;
        pend_nxt = (pend_nxt | rise) & IMPL;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            EXT_ENABLE:  rd_val = en;
            EXT_PENDING: rd_val = pend;
            EXT_STATUS:  rd_val = status;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            en   <= '0;
        end else begin
            pend <= pend_nxt;
            if (wr_en) en <= ((icb_cmd_wdata & bmask) | (en & ~bmask)) & IMPL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_err   <= 1'b0;
            icb_rsp_rdata <= '0;
        end else if (cmd_acc) begin
            icb_rsp_valid <= 1'b1;
            icb_rsp_err   <= (sel == 2'd3);
            icb_rsp_rdata <= icb_cmd_read ? rd_val : 32'd0;
        end else if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|(pend & en)) begin
                        state <= ST_REQ;
                        id    <= prio_enc(pend & en);
                    end
                end
                ST_REQ: begin
                    if (trap_ready_i) state <= ST_SVC;
                end
                ST_SVC: begin
                    if (trap_cplet_i && (trap_cplet_id_i == id)) begin
                        state <= ST_IDLE;
                        id    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    id    <= '0;
                end
            endcase
        end
    end

    assign trap_valid_o = (state == ST_REQ);
    assign trap_id_o    = id;

endmodule

// File: tb/tb_ex_trap_arb.sv
// Directed bench for ex_trap_arb: latency, priority, completion matching,
// non-retractable request, W1C races, ICB behaviour and mid-service reset.
module tb_ex_trap_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq;
    logic        trap_valid;
    logic [4:0]  trap_id;
    logic        trap_ready;
    logic        trap_cplet;
    logic [4:0]  trap_cplet_id;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    ex_trap_arb #(.NSRC(31)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_i           (irq),
        .trap_valid_o    (trap_valid),
        .trap_id_o       (trap_id),
        .trap_ready_i    (trap_ready),
        .trap_cplet_i    (trap_cplet),
        .trap_cplet_id_i (trap_cplet_id),
        .icb_cmd_valid   (cmd_valid),
        .icb_cmd_ready   (cmd_ready),
        .icb_cmd_addr    (cmd_addr),
        .icb_cmd_read    (cmd_read),
        .icb_cmd_wdata   (cmd_wdata),
        .icb_cmd_wmask   (cmd_wmask),
        .icb_rsp_valid   (rsp_valid),
        .icb_rsp_ready   (rsp_ready),
        .icb_rsp_err     (rsp_err),
        .icb_rsp_rdata   (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic icb(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wmask = wmask;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e;
        icb(1'b0, addr, wdata, 4'hF, rd, e);
    endtask

    task automatic reg_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        e;
        icb(1'b1, addr, 32'd0, 4'h0, rd, e);
        check(tag, rd, exp);
    endtask

    task automatic pulse_irq(input int n);
        @(negedge clk);
        irq[n] = 1'b1;
        repeat (3) @(negedge clk);
        irq[n] = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!trap_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, trap_valid}, 32'd1);
    endtask

    task automatic give_ready();
        @(negedge clk);
        trap_ready = 1'b1;
        @(negedge clk);
        trap_ready = 1'b0;
    endtask

    task automatic give_cplet(input logic [4:0] cid);
        @(negedge clk);
        trap_cplet    = 1'b1;
        trap_cplet_id = cid;
        @(negedge clk);
        trap_cplet    = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;

        rst_n = 1'b0;
        irq = '0;
        trap_ready = 1'b0;
        trap_cplet = 1'b0;
        trap_cplet_id = '0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_read = 1'b0;
        cmd_wdata = '0;
        cmd_wmask = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_id", {27'd0, trap_id}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        reg_rd_chk("rst_enable", 32'h0, 32'd0);
        reg_rd_chk("rst_pending", 32'h4, 32'd0);
        reg_rd_chk("rst_status", 32'h8, 32'd0);

        // ICB: byte mask, unmapped offset, alias, RO status, backpressure
        icb(1'b0, 32'h0, 32'hFFFF_FFFF, 4'h1, rd, e);
        check("wr_enable_err", {31'd0, e}, 32'd0);
        reg_rd_chk("enable_wmask", 32'h0, 32'h0000_00FE);
        reg_rd_chk("enable_alias", 32'h1000_0010, 32'h0000_00FE);
        icb(1'b1, 32'hC, 32'd0, 4'h0, rd, e);
        check("unmapped_err", {31'd0, e}, 32'd1);
        check("unmapped_rdata", rd, 32'd0);
        icb(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, rd, e);
        check("status_wr_err", {31'd0, e}, 32'd0);
        reg_rd_chk("status_ro", 32'h8, 32'd0);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h0;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_rdata", rsp_rdata, 32'h0000_00FE);
        check("bp_cmd_ready_0", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("bp_cmd_ready_1", {31'd0, cmd_ready}, 32'd0);
        check("bp_rsp_hold", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        #1;
        check("bp_cmd_ready_rel", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("bp_drained", {31'd0, rsp_valid}, 32'd0);

        // Basic service and interrupt latency
        reg_wr(32'h0, 32'h0000_0002);
        @(negedge clk);
        irq[1] = 1'b1;
        @(negedge clk);
        check("lat_k", {31'd0, trap_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("lat_k2", {31'd0, trap_valid}, 32'd0);
        @(negedge clk);
        check("lat_k3", {31'd0, trap_valid}, 32'd1);
        check("lat_id", {27'd0, trap_id}, 32'd1);
        irq[1] = 1'b0;
        give_ready();
        check("basic_valid_drop", {31'd0, trap_valid}, 32'd0);
        reg_rd_chk("basic_pending", 32'h4, 32'd0);
        reg_rd_chk("basic_status_svc", 32'h8, 32'h8000_0001);
        give_cplet(5'd1);
        reg_rd_chk("basic_status_idle", 32'h8, 32'd0);

        // Priority and back-to-back
        reg_wr(32'h0, 32'hFFFF_FFFE);
        @(negedge clk);
        irq[7] = 1'b1;
        irq[3] = 1'b1;
        wait_valid("prio_wait3");
        check("prio_first", {27'd0, trap_id}, 32'd3);
        irq[7] = 1'b0;
        irq[3] = 1'b0;
        give_ready();
        reg_rd_chk("prio_pending", 32'h4, 32'h0000_0080);
        give_cplet(5'd3);
        check("prio_gap", {31'd0, trap_valid}, 32'd0);
        @(negedge clk);
        check("prio_next_valid", {31'd0, trap_valid}, 32'd1);
        check("prio_next_id", {27'd0, trap_id}, 32'd7);
        give_ready();
        give_cplet(5'd7);

        // Wrong-ID completion
        pulse_irq(5);
        wait_valid("wid_wait");
        check("wid_id", {27'd0, trap_id}, 32'd5);
        give_cplet(5'd5);
        check("cplet_in_req", {31'd0, trap_valid}, 32'd1);
        give_ready();
        give_cplet(5'd6);
        reg_rd_chk("wid_status_held", 32'h8, 32'h8000_0005);
        give_cplet(5'd5);
        reg_rd_chk("wid_status_idle", 32'h8, 32'd0);

        // Non-retractable request
        pulse_irq(4);
        wait_valid("nr_wait");
        check("nr_id", {27'd0, trap_id}, 32'd4);
        reg_wr(32'h0, 32'd0);
        check("nr_valid_en0", {31'd0, trap_valid}, 32'd1);
        check("nr_id_en0", {27'd0, trap_id}, 32'd4);
        reg_wr(32'h4, 32'h0000_0010);
        check("nr_valid_w1c", {31'd0, trap_valid}, 32'd1);
        check("nr_id_w1c", {27'd0, trap_id}, 32'd4);
        give_ready();
        reg_rd_chk("nr_status_svc", 32'h8, 32'h8000_0004);
        give_cplet(5'd4);

        // W1C on the same edge as a new rise on source 9: set wins
        @(negedge clk);
        irq[9] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        reg_wr(32'h4, 32'h0000_0200);
        reg_rd_chk("race_set_wins", 32'h4, 32'h0000_0200);
        irq[9] = 1'b0;
        reg_wr(32'h4, 32'h0000_0200);
        reg_rd_chk("w1c_clears", 32'h4, 32'd0);

        // Reset in SVC with a line held high
        reg_wr(32'h0, 32'hFFFF_FFFE);
        @(negedge clk);
        irq[2] = 1'b1;
        wait_valid("rst_wait");
        check("rst_svc_id", {27'd0, trap_id}, 32'd2);
        give_ready();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, trap_valid}, 32'd0);
        check("mid_rst_id", {27'd0, trap_id}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reg_rd_chk("mid_rst_enable", 32'h0, 32'd0);
        reg_wr(32'h0, 32'h0000_0004);
        repeat (8) @(negedge clk);
        check("held_no_req", {31'd0, trap_valid}, 32'd0);
        reg_rd_chk("held_no_pend", 32'h4, 32'd0);
        irq[2] = 1'b0;
        repeat (3) @(negedge clk);
        irq[2] = 1'b1;
        wait_valid("retrigger_wait");
        check("retrigger_id", {27'd0, trap_id}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
